// File: rtl/conv_window_scheduler.sv
// conv_window_scheduler
//
// Address sequencer for a NO_CORES-wide MAC array running a KxK convolution
// over a square, channel-grouped input image held in block RAM. Once started,
// it issues one image word address and one weight word address per enabled
// cycle. The sweep order, from outermost to innermost, is output channel
// group, output row, output column, kernel row, kernel column and input
// channel group.
//
// Both addresses are built by adding precomputed strides to running pointers,
// so the sweep itself needs no multipliers. The only multipliers are in the
// config path, and their results are registered once per layer.
//
// Ports
//   clk, rst           rising-edge clock and synchronous active-high reset
//   en                 advance enable; when low the sweep freezes
//   init_signal        one-cycle start pulse; config is sampled in IDLE
//   width_input_img    W, input image width (square image)
//   channel_input_img  Cg, input channel groups
//   kernel_size        K, kernel width (1..KMAX)
//   stride             S
//   width_out          Wo, output width (square image)
//   no_channel_out     Og, output channel groups
//   busy               high while the sweep is running
//   addr_valid         img_addr and weight_addr carry an element this cycle
//   img_addr           image BRAM word address
//   weight_addr        weight BRAM word address
//   channel_end        last element of the current output pixel's window
//   out_pixel_idx      oy*Wo+ox of the current element
//   out_ch_grp         current output channel group
//   weight_end         last element of the whole layer
//   cfg_err            one-cycle pulse when init_signal is rejected
module conv_window_scheduler #(
  parameter int ADDR_W   = 32,
  parameter int DIM_W    = 12,
  parameter int KMAX     = 7,
  parameter int NO_CORES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 init_signal,
  input  logic [DIM_W-1:0]     width_input_img,
  input  logic [DIM_W-1:0]     channel_input_img,
  input  logic [3:0]           kernel_size,
  input  logic [2:0]           stride,
  input  logic [DIM_W-1:0]     width_out,
  input  logic [DIM_W-1:0]     no_channel_out,
  output logic                 busy,
  output logic                 addr_valid,
  output logic [ADDR_W-1:0]    img_addr,
  output logic [ADDR_W-1:0]    weight_addr,
  output logic                 channel_end,
  output logic [2*DIM_W-1:0]   out_pixel_idx,
  output logic [DIM_W-1:0]     out_ch_grp,
  output logic                 weight_end,
  output logic                 cfg_err
);

  typedef enum logic {IDLE, RUN} state_t;

  // Wide enough for (Wo-1)*S+K without overflow.
  localparam int RW = DIM_W + 8;
  // An array without MAC lanes has nothing to schedule.
  localparam logic HAS_CORES = (NO_CORES > 0);

  state_t state_reg, state_next;

  // Latched layer configuration and precomputed address strides.
  logic [3:0]        k_reg;
  logic [DIM_W-1:0]  cg_reg, wo_reg, og_reg;
  logic [ADDR_W-1:0] row_step_reg;    // W*Cg: next kernel row
  logic [ADDR_W-1:0] ox_step_reg;     // S*Cg: next output column
  logic [ADDR_W-1:0] oy_step_reg;     // S*W*Cg: next output row
  logic [ADDR_W-1:0] kcube_reg;       // K*K*Cg: next output channel group

  // Loop counters.
  logic [DIM_W-1:0]   c_reg, ox_reg, oy_reg, och_reg;
  logic [3:0]         kx_reg, ky_reg;
  logic [2*DIM_W-1:0] pix_reg;

  // Address pointers. line = window at (oy, 0), win = window at (oy, ox),
  // row = start of the current kernel row, img = current element.
  logic [ADDR_W-1:0] line_ptr_reg, win_ptr_reg, row_ptr_reg, img_ptr_reg;
  logic [ADDR_W-1:0] wbase_reg, w_ptr_reg;

  // Config check.
  logic [RW-1:0] reach;
  logic          cfg_ok;
  logic [ADDR_W-1:0] row_step_in, ox_step_in, oy_step_in, kcube_in;

  always_comb begin
    reach = (RW'(width_out) - RW'(1)) * RW'(stride) + RW'(kernel_size);
    cfg_ok = HAS_CORES
          && (kernel_size != 4'd0) && (stride != 3'd0)
          && (channel_input_img != '0) && (width_out != '0)
          && (no_channel_out != '0)
          && (RW'(kernel_size) <= RW'(KMAX))
          && (reach <= RW'(width_input_img));
    row_step_in = ADDR_W'(width_input_img) * ADDR_W'(channel_input_img);
    ox_step_in  = ADDR_W'(stride) * ADDR_W'(channel_input_img);
    oy_step_in  = ADDR_W'(stride) * row_step_in;
    kcube_in    = ADDR_W'(kernel_size) * ADDR_W'(kernel_size)
                * ADDR_W'(channel_input_img);
  end

  // Wrap detection for each loop level.
  logic last_c, last_kx, last_ky, last_ox, last_oy, last_och;
  logic win_last, layer_last, step;

  always_comb begin
    last_c     = (c_reg   == cg_reg - DIM_W'(1));
    last_kx    = (kx_reg  == k_reg  - 4'd1);
    last_ky    = (ky_reg  == k_reg  - 4'd1);
    last_ox    = (ox_reg  == wo_reg - DIM_W'(1));
    last_oy    = (oy_reg  == wo_reg - DIM_W'(1));
    last_och   = (och_reg == og_reg - DIM_W'(1));
    win_last   = last_c && last_kx && last_ky;
    layer_last = win_last && last_ox && last_oy && last_och;
    step       = (state_reg == RUN) && en;
  end

  // FSM.
  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (init_signal && cfg_ok) state_next = RUN;
      RUN:     if (en && layer_last)      state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Config latch and sweep counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      k_reg <= '0; cg_reg <= '0; wo_reg <= '0; og_reg <= '0;
      row_step_reg <= '0; ox_step_reg <= '0; oy_step_reg <= '0; kcube_reg <= '0;
      c_reg <= '0; kx_reg <= '0; ky_reg <= '0; ox_reg <= '0; oy_reg <= '0;
      och_reg <= '0; pix_reg <= '0;
      line_ptr_reg <= '0; win_ptr_reg <= '0; row_ptr_reg <= '0; img_ptr_reg <= '0;
      wbase_reg <= '0; w_ptr_reg <= '0;
    end else if (state_reg == IDLE) begin
      if (init_signal && cfg_ok) begin
        k_reg        <= kernel_size;
        cg_reg       <= channel_input_img;
        wo_reg       <= width_out;
        og_reg       <= no_channel_out;
        row_step_reg <= row_step_in;
        ox_step_reg  <= ox_step_in;
        oy_step_reg  <= oy_step_in;
        kcube_reg    <= kcube_in;
        c_reg <= '0; kx_reg <= '0; ky_reg <= '0; ox_reg <= '0; oy_reg <= '0;
        och_reg <= '0; pix_reg <= '0;
        line_ptr_reg <= '0; win_ptr_reg <= '0; row_ptr_reg <= '0; img_ptr_reg <= '0;
        wbase_reg <= '0; w_ptr_reg <= '0;
      end
    end else if (step) begin
      if (!(last_c && last_kx)) begin
        // Within one kernel row, (kx, c) walks contiguous words in both
        // memories, so both pointers simply increment.
        if (last_c) begin
          c_reg  <= '0;
          kx_reg <= kx_reg + 4'd1;
        end else begin
          c_reg <= c_reg + DIM_W'(1);
        end
        img_ptr_reg <= img_ptr_reg + ADDR_W'(1);
        w_ptr_reg   <= w_ptr_reg + ADDR_W'(1);
      end else begin
        c_reg  <= '0;
        kx_reg <= '0;
        if (!last_ky) begin
          // The weights stay contiguous across kernel rows. The image jumps
          // down one row.
          ky_reg      <= ky_reg + 4'd1;
          row_ptr_reg <= row_ptr_reg + row_step_reg;
          img_ptr_reg <= row_ptr_reg + row_step_reg;
          w_ptr_reg   <= w_ptr_reg + ADDR_W'(1);
        end else begin
          ky_reg    <= '0;
          w_ptr_reg <= wbase_reg;
          if (!last_ox) begin
            ox_reg      <= ox_reg + DIM_W'(1);
            pix_reg     <= pix_reg + (2*DIM_W)'(1);
            win_ptr_reg <= win_ptr_reg + ox_step_reg;
            row_ptr_reg <= win_ptr_reg + ox_step_reg;
            img_ptr_reg <= win_ptr_reg + ox_step_reg;
          end else begin
            ox_reg <= '0;
            if (!last_oy) begin
              oy_reg       <= oy_reg + DIM_W'(1);
              pix_reg      <= pix_reg + (2*DIM_W)'(1);
              line_ptr_reg <= line_ptr_reg + oy_step_reg;
              win_ptr_reg  <= line_ptr_reg + oy_step_reg;
              row_ptr_reg  <= line_ptr_reg + oy_step_reg;
              img_ptr_reg  <= line_ptr_reg + oy_step_reg;
            end else begin
              // The image plane is done: rewind and move to the next
              // output channel group's weight block.
              oy_reg <= '0;
              pix_reg <= '0;
              line_ptr_reg <= '0; win_ptr_reg <= '0;
              row_ptr_reg  <= '0; img_ptr_reg <= '0;
              if (!last_och) begin
                och_reg   <= och_reg + DIM_W'(1);
                wbase_reg <= wbase_reg + kcube_reg;
                w_ptr_reg <= wbase_reg + kcube_reg;
              end
            end
          end
        end
      end
    end
  end

  // Registered outputs. An element taken on cycle n is presented on cycle n+1.
  // A stall drops addr_valid and holds everything else.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_valid    <= 1'b0;
      img_addr      <= '0;
      weight_addr   <= '0;
      channel_end   <= 1'b0;
      out_pixel_idx <= '0;
      out_ch_grp    <= '0;
      weight_end    <= 1'b0;
      cfg_err       <= 1'b0;
    end else begin
      cfg_err <= (state_reg == IDLE) && init_signal && !cfg_ok;
      if (step) begin
        addr_valid    <= 1'b1;
        img_addr      <= img_ptr_reg;
        weight_addr   <= w_ptr_reg;
        channel_end   <= win_last;
        out_pixel_idx <= pix_reg;
        out_ch_grp    <= och_reg;
        weight_end    <= layer_last;
      end else if (state_reg == RUN) begin
        addr_valid <= 1'b0;
      end else begin
        addr_valid  <= 1'b0;
        channel_end <= 1'b0;
        weight_end  <= 1'b0;
      end
    end
  end

  assign busy = (state_reg == RUN);

endmodule

// File: tb/tb_conv_window_scheduler.sv
module tb_conv_window_scheduler;

  localparam int ADDR_W = 32;
  localparam int DIM_W  = 12;
  localparam int KMAX   = 7;

  logic clk = 1'b0;
  logic rst, en, init_signal;
  logic [DIM_W-1:0]   width_input_img, channel_input_img, width_out, no_channel_out;
  logic [3:0]         kernel_size;
  logic [2:0]         stride;
  logic               busy, addr_valid, channel_end, weight_end, cfg_err;
  logic [ADDR_W-1:0]  img_addr, weight_addr;
  logic [2*DIM_W-1:0] out_pixel_idx;
  logic [DIM_W-1:0]   out_ch_grp;

  conv_window_scheduler #(.ADDR_W(ADDR_W), .DIM_W(DIM_W), .KMAX(KMAX), .NO_CORES(4)) dut (
    .clk(clk), .rst(rst), .en(en), .init_signal(init_signal),
    .width_input_img(width_input_img), .channel_input_img(channel_input_img),
    .kernel_size(kernel_size), .stride(stride), .width_out(width_out),
    .no_channel_out(no_channel_out), .busy(busy), .addr_valid(addr_valid),
    .img_addr(img_addr), .weight_addr(weight_addr), .channel_end(channel_end),
    .out_pixel_idx(out_pixel_idx), .out_ch_grp(out_ch_grp),
    .weight_end(weight_end), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int w, cg, k, s, wo, og;
    bit stall;
    int total;
    int spot_idx, spot_img, spot_w, spot_och;
  } case_t;

  typedef struct {
    longint img, wa;
    bit     ce, we;
    int     pix, och;
  } elem_t;

  case_t layers[7];
  case_t bad_cfgs[4];
  elem_t exp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Reference sweep built straight from the address formulas.
  task automatic build_model(input case_t tc);
    elem_t e;
    exp_q.delete();
    for (int och = 0; och < tc.og; och++)
      for (int oy = 0; oy < tc.wo; oy++)
        for (int ox = 0; ox < tc.wo; ox++)
          for (int ky = 0; ky < tc.k; ky++)
            for (int kx = 0; kx < tc.k; kx++)
              for (int c = 0; c < tc.cg; c++) begin
                e.img = ((oy*tc.s + ky)*tc.w + ox*tc.s + kx)*tc.cg + c;
                e.wa  = och*tc.k*tc.k*tc.cg + (ky*tc.k + kx)*tc.cg + c;
                e.ce  = (ky == tc.k-1) && (kx == tc.k-1) && (c == tc.cg-1);
                e.we  = e.ce && (och == tc.og-1) && (oy == tc.wo-1) && (ox == tc.wo-1);
                e.pix = oy*tc.wo + ox;
                e.och = och;
                exp_q.push_back(e);
              end
  endtask

  task automatic start_layer(input case_t tc);
    width_input_img   = DIM_W'(tc.w);
    channel_input_img = DIM_W'(tc.cg);
    kernel_size       = 4'(tc.k);
    stride            = 3'(tc.s);
    width_out         = DIM_W'(tc.wo);
    no_channel_out    = DIM_W'(tc.og);
    init_signal = 1'b1;
    en = 1'b1;
    @(posedge clk); #1;
    init_signal = 1'b0;
  endtask

  // Runs a layer and checks every valid element against the model.
  // With stop_at > 0, returns right after that many valid elements.
  task automatic run_layer(input case_t tc, input string tag, input int stop_at);
    int  n = 0;
    bit  done = 0;
    bit  en_applied;
    int  budget = tc.total*2 + 50;
    build_model(tc);
    start_layer(tc);
    chk({tag, " busy_after_init"}, 64'(busy), 64'd1);
    chk({tag, " no_valid_yet"}, 64'(addr_valid), 64'd0);
    for (int cyc = 0; cyc < budget && !done; cyc++) begin
      en = !(tc.stall && ((cyc % 8) >= 5));
      en_applied = en;
      @(posedge clk); #1;
      if (!en_applied) chk({tag, " stall_valid"}, 64'(addr_valid), 64'd0);
      if (cyc == 0 && !tc.stall) chk({tag, " first_latency"}, 64'(addr_valid), 64'd1);
      if (addr_valid) begin
        if (n >= exp_q.size()) begin
          chk({tag, " extra_valid"}, 64'(n), 64'(exp_q.size()));
          done = 1;
        end else begin
          if (img_addr !== exp_q[n].img[ADDR_W-1:0] || weight_addr !== exp_q[n].wa[ADDR_W-1:0] ||
              channel_end !== exp_q[n].ce || weight_end !== exp_q[n].we ||
              out_pixel_idx !== (2*DIM_W)'(exp_q[n].pix) || out_ch_grp !== DIM_W'(exp_q[n].och)) begin
            errors++;
            $display("FAIL %s elem %0d: img=%0d wa=%0d ce=%0b we=%0b pix=%0d och=%0d, expected img=%0d wa=%0d ce=%0b we=%0b pix=%0d och=%0d",
                     tag, n, img_addr, weight_addr, channel_end, weight_end, out_pixel_idx, out_ch_grp,
                     exp_q[n].img, exp_q[n].wa, exp_q[n].ce, exp_q[n].we, exp_q[n].pix, exp_q[n].och);
          end
          checks++;
          if (n == tc.spot_idx) begin
            chk({tag, " spot_img"}, 64'(img_addr), 64'(tc.spot_img));
            chk({tag, " spot_w"}, 64'(weight_addr), 64'(tc.spot_w));
            chk({tag, " spot_och"}, 64'(out_ch_grp), 64'(tc.spot_och));
          end
          n++;
          if (weight_end) done = 1;
          if (stop_at > 0 && n == stop_at) done = 1;
        end
      end
    end
    en = 1'b1;
    if (stop_at == 0) begin
      chk({tag, " finished_in_budget"}, 64'(done), 64'd1);
      chk({tag, " valid_count"}, 64'(n), 64'(tc.total));
      @(posedge clk); #1;
      chk({tag, " busy_after_end"}, 64'(busy), 64'd0);
      chk({tag, " valid_after_end"}, 64'(addr_valid), 64'd0);
    end
    $display("layer %s: %0d valid elements", tag, n);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, " busy"}, 64'(busy), 64'd0);
    chk({tag, " addr_valid"}, 64'(addr_valid), 64'd0);
    chk({tag, " img_addr"}, 64'(img_addr), 64'd0);
    chk({tag, " weight_addr"}, 64'(weight_addr), 64'd0);
    chk({tag, " channel_end"}, 64'(channel_end), 64'd0);
    chk({tag, " out_pixel_idx"}, 64'(out_pixel_idx), 64'd0);
    chk({tag, " out_ch_grp"}, 64'(out_ch_grp), 64'd0);
    chk({tag, " weight_end"}, 64'(weight_end), 64'd0);
    chk({tag, " cfg_err"}, 64'(cfg_err), 64'd0);
  endtask

  initial begin
    //          w  cg k  s  wo og stall total spot: idx img  w   och
    layers[0] = '{5, 2, 3, 1, 3, 1, 1'b0, 162,  18,  2,   0,  0};
    layers[1] = '{5, 2, 3, 2, 2, 1, 1'b0,  72,  18,  4,   0,  0};
    layers[2] = '{5, 2, 3, 2, 2, 1, 1'b0,  72,  36, 20,   0,  0};
    layers[3] = '{5, 2, 3, 1, 3, 2, 1'b0, 324, 162,  0,  18,  1};
    layers[4] = '{5, 2, 3, 1, 3, 1, 1'b1, 162,  18,  2,   0,  0};
    layers[5] = '{4, 1, 1, 1, 4, 1, 1'b0,  16,   5,  5,   0,  0};
    layers[6] = '{7, 1, 7, 1, 1, 1, 1'b0,  49,  48, 48,  48,  0};

    bad_cfgs[0] = '{5, 2, 3, 1, 4, 1, 1'b0, 0, 0, 0, 0, 0};   // window overruns W
    bad_cfgs[1] = '{5, 2, 0, 1, 3, 1, 1'b0, 0, 0, 0, 0, 0};   // K = 0
    bad_cfgs[2] = '{10, 1, 8, 1, 1, 1, 1'b0, 0, 0, 0, 0, 0};  // K > KMAX
    bad_cfgs[3] = '{5, 2, 3, 1, 3, 0, 1'b0, 0, 0, 0, 0, 0};   // Og = 0

    rst = 1'b1; en = 1'b0; init_signal = 1'b0;
    width_input_img = '0; channel_input_img = '0; kernel_size = '0;
    stride = '0; width_out = '0; no_channel_out = '0;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 7; i++) begin
      run_layer(layers[i], $sformatf("L%0d", i), 0);
      @(posedge clk); #1;
    end

    for (int i = 0; i < 4; i++) begin
      start_layer(bad_cfgs[i]);
      chk($sformatf("bad%0d cfg_err", i), 64'(cfg_err), 64'd1);
      chk($sformatf("bad%0d busy", i), 64'(busy), 64'd0);
      @(posedge clk); #1;
      chk($sformatf("bad%0d cfg_err_pulse", i), 64'(cfg_err), 64'd0);
      chk($sformatf("bad%0d busy_next", i), 64'(busy), 64'd0);
      chk($sformatf("bad%0d valid", i), 64'(addr_valid), 64'd0);
      $display("bad config %0d rejected check done", i);
    end

    // Reset in the middle of a layer, then a clean restart.
    run_layer(layers[0], "pre_rst", 40);
    rst = 1'b1;
    @(posedge clk); #1;
    check_all_zero("mid_rst");
    rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst weight_end", 64'(weight_end), 64'd0);
    chk("post_rst valid", 64'(addr_valid), 64'd0);
    run_layer(layers[0], "after_rst", 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
